// File: rtl/branch_resolve_queue.sv
// In-order branch resolution queue: records fetched branches with their predictions,
// checks them against execute's in-order resolutions, trains the predictor and redirects on mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alloc_valid,
    output logic        alloc_ready,
    input  logic [31:0] alloc_pc,
    input  logic        alloc_pred_taken,
    input  logic [31:0] alloc_pred_target,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        update_en,
    output logic [31:0] update_pc,
    output logic        actual_taken,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        res_err,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [31:0]      C_SAT     = 32'hFFFF_FFFF;

    // A taken branch with a wrong target is as much a mispredict as a wrong direction.
    function automatic logic f_mispredict(
        input logic        pred_taken,
        input logic [31:0] pred_target,
        input logic        act_taken,
        input logic [31:0] act_target
    );
        return (act_taken != pred_taken) ||
               (act_taken && pred_taken && (act_target != pred_target));
    endfunction

    logic [31:0]      r_pc_mem  [DEPTH];
    logic             r_pt_mem  [DEPTH];
    logic [31:0]      r_tgt_mem [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             r_update_en;
    logic [31:0]      r_update_pc;
    logic             r_actual_taken;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic             r_res_err;
    logic [31:0]      r_stat_branches;
    logic [31:0]      r_stat_mispredicts;

    logic             w_alloc_ready;
    logic             w_empty;
    logic             w_pop;
    logic             w_mispredict;
    logic             w_push;
    logic [31:0]      w_head_pc;
    logic             w_head_pt;
    logic [31:0]      w_head_tgt;
    logic [31:0]      w_redirect_pc;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [PTR_W:0]   w_count_nxt;

    assign w_alloc_ready = (r_count != C_FULL);
    assign w_empty       = (r_count == {(PTR_W+1){1'b0}});
    assign w_pop         = res_valid && !w_empty;
    assign w_head_pc     = r_pc_mem[r_head];
    assign w_head_pt     = r_pt_mem[r_head];
    assign w_head_tgt    = r_tgt_mem[r_head];
    assign w_mispredict  = w_pop && f_mispredict(w_head_pt, w_head_tgt, res_taken, res_target);
    // A push in the flushing cycle is wrong-path and is dropped despite alloc_ready.
    assign w_push        = alloc_valid && w_alloc_ready && !w_mispredict;
    assign w_redirect_pc = res_taken ? res_target : (w_head_pc + 32'd4);

    // Pointer and occupancy next-state, with flush overriding normal push/pop.
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_mispredict) begin
            w_head_nxt  = r_tail;
            w_count_nxt = {(PTR_W+1){1'b0}};
        end else begin
            if (w_pop) begin
                w_head_nxt = r_head + C_PTR_ONE;
            end else begin
                w_head_nxt = r_head;
            end
            if (w_push) begin
                w_tail_nxt = r_tail + C_PTR_ONE;
            end else begin
                w_tail_nxt = r_tail;
            end
            if (w_push && !w_pop) begin
                w_count_nxt = r_count + C_CNT_ONE;
            end else if (w_pop && !w_push) begin
                w_count_nxt = r_count - C_CNT_ONE;
            end else begin
                w_count_nxt = r_count;
            end
        end
    end

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]  <= alloc_pc;
            r_pt_mem[r_tail]  <= alloc_pred_taken;
            r_tgt_mem[r_tail] <= alloc_pred_target;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {(PTR_W+1){1'b0}};
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Registered training/redirect outputs, error flag and saturating statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_update_en        <= 1'b0;
            r_update_pc        <= 32'd0;
            r_actual_taken     <= 1'b0;
            r_redirect_valid   <= 1'b0;
            r_redirect_pc      <= 32'd0;
            r_res_err          <= 1'b0;
            r_stat_branches    <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            r_update_en      <= w_pop;
            r_redirect_valid <= w_mispredict;
            if (w_pop) begin
                r_update_pc    <= w_head_pc;
                r_actual_taken <= res_taken;
                if (r_stat_branches != C_SAT) begin
                    r_stat_branches <= r_stat_branches + 32'd1;
                end
            end
            if (w_mispredict) begin
                r_redirect_pc <= w_redirect_pc;
                if (r_stat_mispredicts != C_SAT) begin
                    r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
                end
            end
            if (res_valid && w_empty) begin
                r_res_err <= 1'b1;
            end
        end
    end

    assign alloc_ready      = w_alloc_ready;
    assign update_en        = r_update_en;
    assign update_pc        = r_update_pc;
    assign actual_taken     = r_actual_taken;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign res_err          = r_res_err;
    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed, table-driven bench for branch_resolve_queue plus hand sequences for
// full-queue, wrap and asynchronous-reset corner cases.
module tb_branch_resolve_queue;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_pc;
    logic        alloc_pred_taken;
    logic [31:0] alloc_pred_target;
    logic        res_valid;
    logic        res_taken;
    logic [31:0] res_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic        actual_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        res_err;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_checks;
    int n_errors;

    branch_resolve_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .alloc_pc          (alloc_pc),
        .alloc_pred_taken  (alloc_pred_taken),
        .alloc_pred_target (alloc_pred_target),
        .res_valid         (res_valid),
        .res_taken         (res_taken),
        .res_target        (res_target),
        .update_en         (update_en),
        .update_pc         (update_pc),
        .actual_taken      (actual_taken),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .res_err           (res_err),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [31:0] apc;
        logic        apt;
        logic [31:0] atg;
        logic        rv;
        logic        rt;
        logic [31:0] rtg;
        logic        e_ue;
        logic [31:0] e_upc;
        logic        e_at;
        logic        e_rdv;
        logic [31:0] e_rpc;
        logic        e_err;
        logic [31:0] e_br;
        logic [31:0] e_mp;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid       = 1'b0;
        alloc_pc          = 32'd0;
        alloc_pred_taken  = 1'b0;
        alloc_pred_target = 32'd0;
        res_valid         = 1'b0;
        res_taken         = 1'b0;
        res_target        = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " update_en"},        {31'd0, update_en},      32'd0);
        chk({tag, " update_pc"},        update_pc,               32'd0);
        chk({tag, " actual_taken"},     {31'd0, actual_taken},   32'd0);
        chk({tag, " redirect_valid"},   {31'd0, redirect_valid}, 32'd0);
        chk({tag, " redirect_pc"},      redirect_pc,             32'd0);
        chk({tag, " res_err"},          {31'd0, res_err},        32'd0);
        chk({tag, " stat_branches"},    stat_branches,           32'd0);
        chk({tag, " stat_mispredicts"}, stat_mispredicts,        32'd0);
        chk({tag, " count"},            {28'd0, dut.r_count},    32'd0);
        chk({tag, " alloc_ready"},      {31'd0, alloc_ready},    32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_inputs();

        //          av   apc           apt   atg           rv    rt    rtg           ue    upc           at    rdv   rpc           err   br     mp     cnt
        vecs[0]  = '{1'b1, 32'h0000_2000, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'd0, 32'd0, 4'd1};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0,        1'b0, 32'd1, 32'd0, 4'd0};
        vecs[2]  = '{1'b1, 32'h0000_3000, 1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_2000, 1'b0, 1'b0, 32'h0,        1'b0, 32'd1, 32'd0, 4'd1};
        vecs[3]  = '{1'b1, 32'h0000_3004, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_2000, 1'b0, 1'b0, 32'h0,        1'b0, 32'd1, 32'd0, 4'd2};
        vecs[4]  = '{1'b1, 32'h0000_3008, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_2000, 1'b0, 1'b0, 32'h0,        1'b0, 32'd1, 32'd0, 4'd3};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_3000, 1'b0, 1'b1, 32'h0000_3004, 1'b0, 32'd2, 32'd1, 4'd0};
        vecs[6]  = '{1'b1, 32'h0000_3F00, 1'b1, 32'h0000_4000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_3000, 1'b0, 1'b0, 32'h0000_3004, 1'b0, 32'd2, 32'd1, 4'd1};
        vecs[7]  = '{1'b1, 32'h0000_5000, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_4040, 1'b1, 32'h0000_3F00, 1'b1, 1'b1, 32'h0000_4040, 1'b0, 32'd3, 32'd2, 4'd0};
        vecs[8]  = '{1'b1, 32'h0000_6000, 1'b1, 32'h0000_6100, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_3F00, 1'b1, 1'b0, 32'h0000_4040, 1'b0, 32'd3, 32'd2, 4'd1};
        vecs[9]  = '{1'b1, 32'h0000_6004, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_6100, 1'b1, 32'h0000_6000, 1'b1, 1'b0, 32'h0000_4040, 1'b0, 32'd4, 32'd2, 4'd1};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_7000, 1'b1, 32'h0000_6004, 1'b1, 1'b1, 32'h0000_7000, 1'b0, 32'd5, 32'd3, 4'd0};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0000_6004, 1'b1, 1'b0, 32'h0000_7000, 1'b1, 32'd5, 32'd3, 4'd0};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0000_6004, 1'b1, 1'b0, 32'h0000_7000, 1'b1, 32'd5, 32'd3, 4'd0};

        #12;
        rst = 1'b0;
        step();
        chk_all_zero("reset");

        // Table: single pops, direction/target mispredicts, flush drop, empty resolve.
        for (int i = 0; i < 13; i++) begin
            alloc_valid       = vecs[i].av;
            alloc_pc          = vecs[i].apc;
            alloc_pred_taken  = vecs[i].apt;
            alloc_pred_target = vecs[i].atg;
            res_valid         = vecs[i].rv;
            res_taken         = vecs[i].rt;
            res_target        = vecs[i].rtg;
            step();
            chk($sformatf("v%0d update_en", i),        {31'd0, update_en},      {31'd0, vecs[i].e_ue});
            chk($sformatf("v%0d update_pc", i),        update_pc,               vecs[i].e_upc);
            chk($sformatf("v%0d actual_taken", i),     {31'd0, actual_taken},   {31'd0, vecs[i].e_at});
            chk($sformatf("v%0d redirect_valid", i),   {31'd0, redirect_valid}, {31'd0, vecs[i].e_rdv});
            chk($sformatf("v%0d redirect_pc", i),      redirect_pc,             vecs[i].e_rpc);
            chk($sformatf("v%0d res_err", i),          {31'd0, res_err},        {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d stat_branches", i),    stat_branches,           vecs[i].e_br);
            chk($sformatf("v%0d stat_mispredicts", i), stat_mispredicts,        vecs[i].e_mp);
            chk($sformatf("v%0d count", i),            {28'd0, dut.r_count},    {28'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d alloc_ready", i),      {31'd0, alloc_ready},    {31'd0, (vecs[i].e_cnt != 4'd8)});
        end

        // Fill to capacity with alloc_valid held.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1;
            alloc_pc    = 32'h0000_1000 + 32'(4 * i);
            step();
        end
        chk("full alloc_ready", {31'd0, alloc_ready}, 32'd0);
        chk("full count", {28'd0, dut.r_count}, 32'd8);
        chk("full tail", {29'd0, dut.r_tail}, 32'd0);
        alloc_pc = 32'h0000_1020;
        step();
        chk("ninth count", {28'd0, dut.r_count}, 32'd8);
        chk("ninth tail", {29'd0, dut.r_tail}, 32'd0);
        // Full queue: push refused, correct pop performed.
        res_valid = 1'b1;
        res_taken = 1'b0;
        step();
        chk("fullpop count", {28'd0, dut.r_count}, 32'd7);
        chk("fullpop update_en", {31'd0, update_en}, 32'd1);
        chk("fullpop update_pc", update_pc, 32'h0000_1000);
        chk("fullpop redirect_valid", {31'd0, redirect_valid}, 32'd0);
        res_valid = 1'b0;
        step();
        chk("refill count", {28'd0, dut.r_count}, 32'd8);
        chk("refill tail", {29'd0, dut.r_tail}, 32'd1);
        chk("refill alloc_ready", {31'd0, alloc_ready}, 32'd0);
        // Drain in order; the refilled 0x1020 entry comes out last.
        alloc_valid = 1'b0;
        res_valid   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("drain%0d update_pc", k), update_pc, 32'h0000_1004 + 32'(4 * k));
            chk($sformatf("drain%0d update_en", k), {31'd0, update_en}, 32'd1);
        end
        res_valid = 1'b0;
        step();
        chk("drain count", {28'd0, dut.r_count}, 32'd0);
        chk("drain stat_branches", stat_branches, 32'd9);
        chk("drain stat_mispredicts", stat_mispredicts, 32'd0);
        chk("drain update_en", {31'd0, update_en}, 32'd0);

        // Empty resolve, then asynchronous reset with 5 entries queued.
        do_reset();
        chk_all_zero("reset2");
        res_valid = 1'b1;
        step();
        chk("empty res_err", {31'd0, res_err}, 32'd1);
        chk("empty update_en", {31'd0, update_en}, 32'd0);
        chk("empty stat_branches", stat_branches, 32'd0);
        res_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            alloc_valid = 1'b1;
            alloc_pc    = 32'h0000_8000 + 32'(4 * i);
            step();
        end
        alloc_valid = 1'b0;
        res_valid   = 1'b1;
        step();
        res_valid = 1'b0;
        chk("pre-rst count", {28'd0, dut.r_count}, 32'd5);
        chk("pre-rst update_en", {31'd0, update_en}, 32'd1);
        chk("pre-rst res_err", {31'd0, res_err}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async-rst");
        #2;
        rst = 1'b0;
        step();
        chk_all_zero("post-rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between fetch and execute. It is the producer of the predictor's training interface: update_en, update_pc and actual_taken.
- Records every fetched branch together with its prediction in an in-order FIFO. Checks each entry against the in-order resolution coming from execute.
- Drives one predictor update per resolved branch. On a mispredict, issues a one-cycle redirect and squashes all younger (wrong-path) entries.

Parameters:
- DEPTH, 8, number of in-flight branch entries (power of two, >= 2).
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- alloc_valid  input  1  fetch presents a branch.
- alloc_ready  output  1  queue can accept an entry.
- alloc_pc  input  32  PC of the fetched branch.
- alloc_pred_taken  input  1  predictor MSB at fetch.
- alloc_pred_target  input  32  predicted target (ignored when not taken).
- res_valid  input  1  execute resolves the oldest branch this cycle.
- res_taken  input  1  actual direction.
- res_target  input  32  actual target (meaningful when taken).
- update_en  output  1  predictor update strobe.
- update_pc  output  32  PC of the resolved branch.
- actual_taken  output  1  resolved direction.
- redirect_valid  output  1  mispredict redirect pulse.
- redirect_pc  output  32  correct next PC.
- res_err  output  1  sticky: resolution arrived while the queue was empty.
- stat_branches  output  32  resolved branch count.
- stat_mispredicts  output  32  mispredict count.

Behaviour:
- Storage: circular buffer with head (oldest) and tail pointers, each PTR_W bits and wrapping modulo DEPTH. count is PTR_W+1 bits.
- Each entry holds {pc, pred_taken, pred_target}. Tail advances on push; head advances on pop.
- alloc_ready = (count != DEPTH). It is combinational and ignores any same-cycle pop, so a full queue refuses a push even when a pop happens that cycle.
- Push occurs when alloc_valid && alloc_ready, except when it is squashed (see flush below).
- Pop occurs when res_valid && count != 0, and targets the entry at head.
- res_valid while count == 0:
  - no pop and no update;
  - res_err is set and stays 1 until reset.
- Mispredict is defined as (res_taken != pred_taken) || (res_taken && pred_taken && res_target != pred_target).
- Outputs are registered and appear the cycle after the pop:
  - update_en = 1 for exactly one cycle;
  - update_pc = entry pc;
  - actual_taken = res_taken.
- On a mispredict:
  - redirect_valid = 1 for one cycle, in the same cycle as update_en;
  - redirect_pc = res_taken ? res_target : entry pc + 32'd4 (32-bit wrap).
- Flush on mispredict: in the pop cycle, head <= tail and count <= 0.
  - Every younger entry is discarded.
  - A push requested in that same cycle is dropped. It is wrong-path and is not acknowledged as stored, even though alloc_ready was 1.
- Push and pop in the same cycle without a mispredict: count is unchanged and both pointers advance.
- Counters:
  - stat_branches increments on every pop;
  - stat_mispredicts increments on every mispredicting pop;
  - both saturate at 32'hFFFFFFFF.
- Reset (asynchronous, at any time, including mid-flush): head = tail = count = 0, update_en = 0, update_pc = 0, actual_taken = 0, redirect_valid = 0, redirect_pc = 0, res_err = 0, both counters = 0. Entry contents do not need to be reset.
- Between pulses, update_pc, actual_taken and redirect_pc hold their last values.

Test Plan:
- Reset, then push 8 entries (PC 0x1000, 0x1004, ..., 0x101C) with alloc_valid held -> alloc_ready = 0 after the 8th push; a 9th push is not stored; count = 8.
- Entry PC 0x2000 predicted not taken; resolve res_taken = 0 -> next cycle update_en = 1, update_pc = 0x2000, actual_taken = 0, redirect_valid = 0, stat_branches = 1.
- Entries 0x3000 (predicted taken to 0x3100), 0x3004, 0x3008 queued; resolve oldest with res_taken = 0 -> next cycle redirect_valid = 1, redirect_pc = 0x3004, stat_mispredicts = 1; queue empty, alloc_ready = 1.
- Predicted taken to 0x4000; resolve taken to 0x4040 -> redirect_pc = 0x4040; a push issued in the resolving cycle is not stored (count = 0 afterwards).
- Queue full; same cycle alloc_valid = 1 and a correctly predicted resolve -> push refused, pop performed, count = 7. Next cycle push accepted, count = 8, and tail has wrapped to 0 after 8 total pushes.
- res_valid with an empty queue -> res_err = 1 and update_en stays 0. Assert rst mid-stream with 5 entries queued -> all outputs 0 immediately, count = 0, res_err = 0.
